vrf_sequencer: RTL and testbench

VRF_SEQUENCER -- requirements
Module: vrf_sequencer

---
 rtl/vrf_sequencer.sv | 125 ++++++++++++
 tb/tb_vrf_sequencer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrf_sequencer.sv
// Vector register-file sequencer: walks an instruction through ceil(vl/4) read/write
// beats, stepping the source and destination register addresses by element width.
module vrf_sequencer (
    input  logic       clk,
    input  logic       n_reset,
    input  logic       issue_valid,
    output logic       issue_ready,
    input  logic [4:0] issue_vs1,
    input  logic [4:0] issue_vs2,
    input  logic [4:0] issue_vd,
    input  logic [1:0] issue_vsew,
    input  logic [5:0] issue_vl,
    input  logic       issue_widening,
    input  logic       flush,
    input  logic       result_valid,
    output logic [4:0] vs1_addr,
    output logic [4:0] vs2_addr,
    output logic [4:0] vd_addr,
    output logic [1:0] vsew,
    output logic       widening_op,
    output logic [1:0] elements_to_write,
    output logic       write,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] fsm_state
);

    // Issue handshake: an instruction moves when issue_valid && issue_ready at a rising
    // edge and flush is low; issue_ready is high exactly when the sequencer is idle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t     state;
    logic [5:0] rem;
    logic       accept;
    logic       illegal;
    logic       beat_done;
    logic       last_beat;
    logic [1:0] eff_vsew;
    logic [4:0] src_step;
    logic [4:0] dst_step;

    assign issue_ready = (state == IDLE);
    assign busy        = (state != IDLE);
    assign fsm_state   = state;

    assign accept    = issue_valid && issue_ready && !flush;
    assign illegal   = (issue_vsew == 2'd3) || (issue_widening && (issue_vsew == 2'd2));
    assign beat_done = (state == WRITE) && result_valid && !flush;
    assign last_beat = (rem <= 6'd4);

    // Legal instructions never exceed an effective width code of 2.
    assign eff_vsew = vsew + {1'b0, widening_op};
    assign src_step = 5'd1 << vsew;
    assign dst_step = 5'd1 << eff_vsew;

    // A beat aimed at v0 still retires, but never strobes the register file.
    assign write             = beat_done && (vd_addr != 5'd0);
    assign elements_to_write = (rem >= 6'd4) ? 2'd0 : rem[1:0];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= IDLE;
            rem         <= 6'd0;
            vs1_addr    <= 5'd0;
            vs2_addr    <= 5'd0;
            vd_addr     <= 5'd0;
            vsew        <= 2'd0;
            widening_op <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (accept) begin
                            vs1_addr    <= issue_vs1;
                            vs2_addr    <= issue_vs2;
                            vd_addr     <= issue_vd;
                            vsew        <= issue_vsew;
                            widening_op <= issue_widening;
                            rem         <= issue_vl;
                            if (illegal) begin
                                error <= 1'b1;
                            end else if (issue_vl == 6'd0) begin
                                done <= 1'b1;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                    READ: begin
                        state <= WRITE;
                    end
                    WRITE: begin
                        if (beat_done) begin
                            if (last_beat) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                rem      <= rem - 6'd4;
                                vs1_addr <= vs1_addr + src_step;
                                vs2_addr <= vs2_addr + src_step;
                                vd_addr  <= vd_addr + dst_step;
                                state    <= READ;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vrf_sequencer.sv
// Randomized and directed bench for vrf_sequencer: a cycle-level model of the beat
// sequence feeds expected strobes and write contents to a negedge monitor.
module tb_vrf_sequencer;

    logic       clk = 1'b0;
    logic       n_reset;
    logic       issue_valid;
    logic       issue_ready;
    logic [4:0] issue_vs1;
    logic [4:0] issue_vs2;
    logic [4:0] issue_vd;
    logic [1:0] issue_vsew;
    logic [5:0] issue_vl;
    logic       issue_widening;
    logic       flush;
    logic       result_valid;
    logic [4:0] vs1_addr;
    logic [4:0] vs2_addr;
    logic [4:0] vd_addr;
    logic [1:0] vsew;
    logic       widening_op;
    logic [1:0] elements_to_write;
    logic       write;
    logic       busy;
    logic       done;
    logic       error;
    logic [1:0] fsm_state;

    int checks = 0;
    int errors = 0;

    // Per-cycle expectation: {chk_addr, vs1, vs2, vd, ets, ready, busy, write, done, error}
    logic [22:0] st_q[$];
    // Per-write expectation: {vs1, vs2, vd, ets, vsew, widening}
    logic [19:0] wr_q[$];

    vrf_sequencer dut (
        .clk               (clk),
        .n_reset           (n_reset),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_vs1         (issue_vs1),
        .issue_vs2         (issue_vs2),
        .issue_vd          (issue_vd),
        .issue_vsew        (issue_vsew),
        .issue_vl          (issue_vl),
        .issue_widening    (issue_widening),
        .flush             (flush),
        .result_valid      (result_valid),
        .vs1_addr          (vs1_addr),
        .vs2_addr          (vs2_addr),
        .vd_addr           (vd_addr),
        .vsew              (vsew),
        .widening_op       (widening_op),
        .elements_to_write (elements_to_write),
        .write             (write),
        .busy              (busy),
        .done              (done),
        .error             (error),
        .fsm_state         (fsm_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // ---------------- helpers ----------------
    function automatic logic [22:0] mk(input logic chk, input logic [4:0] a1, input logic [4:0] a2,
                                       input logic [4:0] ad, input logic [1:0] ets, input logic rdy,
                                       input logic bsy, input logic wr, input logic dn, input logic er);
        return {chk, a1, a2, ad, ets, rdy, bsy, wr, dn, er};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Pushes the expectation for the current cycle, then advances to just after the next edge.
    task automatic cyc(input logic [22:0] e);
        st_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [22:0] idle_exp(input logic dn, input logic er);
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, dn, er);
    endfunction

    // ---------------- driver + reference model ----------------
    task automatic run_instr(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                             input logic [1:0] sew, input logic [5:0] vl, input logic wid,
                             input int rv_pct, input int flush_beat, input int hold0);
        logic [4:0] a1, a2, ad;
        logic [1:0] ets;
        logic       rv, flushed, wdone;
        int         nbeats, rem, lows, sstep, dstep;
        issue_vs1 = s1;
        issue_vs2 = s2;
        issue_vd = d;
        issue_vsew = sew;
        issue_vl = vl;
        issue_widening = wid;
        issue_valid = 1'b1;
        result_valid = 1'($urandom_range(0, 1));
        cyc(idle_exp(1'b0, 1'b0));
        issue_valid = 1'b0;
        if (sew == 2'd3 || (wid && sew == 2'd2)) begin
            result_valid = 1'($urandom_range(0, 1));
            cyc(idle_exp(1'b0, 1'b1));
            return;
        end
        if (vl == 6'd0) begin
            cyc(idle_exp(1'b1, 1'b0));
            return;
        end
        nbeats = (int'(vl) + 3) / 4;
        sstep = 1 << int'(sew);
        dstep = 1 << (int'(sew) + int'(wid));
        flushed = 1'b0;
        for (int k = 0; k < nbeats && !flushed; k++) begin
            a1 = 5'((int'(s1) + k * sstep) % 32);
            a2 = 5'((int'(s2) + k * sstep) % 32);
            ad = 5'((int'(d) + k * dstep) % 32);
            rem = int'(vl) - 4 * k;
            ets = (rem >= 4) ? 2'd0 : 2'(rem);
            result_valid = (rv_pct >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
            issue_valid = 1'($urandom_range(0, 1));
            cyc(mk(1'b1, a1, a2, ad, ets, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
            lows = 0;
            wdone = 1'b0;
            while (!wdone) begin
                issue_valid = 1'($urandom_range(0, 1));
                if (k == flush_beat) begin
                    flush = 1'b1;
                    result_valid = 1'b1;
                    cyc(mk(1'b1, a1, a2, ad, ets, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
                    flush = 1'b0;
                    flushed = 1'b1;
                    wdone = 1'b1;
                end else begin
                    if (k == 0 && lows < hold0) rv = 1'b0;
                    else if (lows >= 3 || rv_pct >= 100) rv = 1'b1;
                    else rv = (int'($urandom_range(0, 99)) < rv_pct);
                    result_valid = rv;
                    if (rv && ad != 5'd0) wr_q.push_back({a1, a2, ad, ets, sew, wid});
                    cyc(mk(1'b1, a1, a2, ad, ets, 1'b0, 1'b1, rv && (ad != 5'd0), 1'b0, 1'b0));
                    if (rv) wdone = 1'b1;
                    else lows++;
                end
            end
        end
        issue_valid = 1'b0;
        result_valid = 1'b0;
        cyc(idle_exp(!flushed, 1'b0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [22:0] e;
        logic [19:0] w;
        if (n_reset) begin
            if (st_q.size() > 0) begin
                e = st_q.pop_front();
                checks++;
                if ({issue_ready, busy, write, done, error} !== e[4:0]) begin
                    errors++;
                    $display("FAIL strobes rdy/busy/wr/done/err act=%b exp=%b t=%0t",
                             {issue_ready, busy, write, done, error}, e[4:0], $time);
                end
                if (e[22]) begin
                    checks++;
                    if ({vs1_addr, vs2_addr, vd_addr, elements_to_write} !== e[21:5]) begin
                        errors++;
                        $display("FAIL beat_addrs act=%0d/%0d/%0d ets=%0d exp=%0d/%0d/%0d ets=%0d t=%0t",
                                 vs1_addr, vs2_addr, vd_addr, elements_to_write,
                                 e[21:17], e[16:12], e[11:7], e[6:5], $time);
                    end
                end
            end
            if (write) begin
                checks++;
                if (wr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write vd=%0d t=%0t", vd_addr, $time);
                end else begin
                    w = wr_q.pop_front();
                    if ({vs1_addr, vs2_addr, vd_addr, elements_to_write, vsew, widening_op} !== w) begin
                        errors++;
                        $display("FAIL write_data act=%h exp=%h t=%0t",
                                 {vs1_addr, vs2_addr, vd_addr, elements_to_write, vsew, widening_op}, w, $time);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int nb, fb;
        logic [1:0] rsew;
        logic [5:0] rvl;
        n_reset = 1'b0;
        issue_valid = 1'b0;
        issue_vs1 = 5'd0;
        issue_vs2 = 5'd0;
        issue_vd = 5'd0;
        issue_vsew = 2'd0;
        issue_vl = 6'd0;
        issue_widening = 1'b0;
        flush = 1'b0;
        result_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {8'd0, vs1_addr, vs2_addr, vd_addr, vsew, widening_op,
                                elements_to_write, write, busy, done, error}, 32'd0);
        check("reset_ready", {31'd0, issue_ready}, 32'd1);
        n_reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed scenarios.
        run_instr(5'd8, 5'd16, 5'd24, 2'd0, 6'd10, 1'b0, 100, -1, 0);
        run_instr(5'd3, 5'd5, 5'd8, 2'd2, 6'd6, 1'b0, 70, -1, 0);
        run_instr(5'd1, 5'd4, 5'd8, 2'd1, 6'd8, 1'b1, 70, -1, 0);
        run_instr(5'd1, 5'd2, 5'd3, 2'd2, 6'd8, 1'b1, 70, -1, 0);
        run_instr(5'd1, 5'd2, 5'd3, 2'd3, 6'd8, 1'b0, 70, -1, 0);
        run_instr(5'd1, 5'd2, 5'd3, 2'd1, 6'd0, 1'b0, 70, -1, 0);
        run_instr(5'd1, 5'd2, 5'd3, 2'd0, 6'd8, 1'b0, 100, 1, 3);
        run_instr(5'd7, 5'd9, 5'd30, 2'd2, 6'd8, 1'b0, 100, -1, 0);
        run_instr(5'd2, 5'd2, 5'd31, 2'd0, 6'd7, 1'b0, 100, -1, 0);
        run_instr(5'd31, 5'd30, 5'd28, 2'd1, 6'd32, 1'b1, 60, -1, 0);

        // Flush coinciding with an offered issue must not accept it.
        issue_vsew = 2'd0;
        issue_vl = 6'd8;
        issue_widening = 1'b0;
        issue_valid = 1'b1;
        flush = 1'b1;
        cyc(idle_exp(1'b0, 1'b0));
        issue_valid = 1'b0;
        flush = 1'b0;
        cyc(idle_exp(1'b0, 1'b0));

        // Reset asserted during READ clears everything at once.
        issue_vs1 = 5'd4;
        issue_vs2 = 5'd6;
        issue_vd = 5'd5;
        issue_vsew = 2'd0;
        issue_vl = 6'd8;
        issue_valid = 1'b1;
        cyc(idle_exp(1'b0, 1'b0));
        issue_valid = 1'b0;
        #1 n_reset = 1'b0;
        #1;
        check("midreset_outputs", {8'd0, vs1_addr, vs2_addr, vd_addr, vsew, widening_op,
                                   elements_to_write, write, busy, done, error}, 32'd0);
        check("midreset_ready", {31'd0, issue_ready}, 32'd1);
        @(posedge clk);
        #1 n_reset = 1'b1;
        result_valid = 1'b1;
        repeat (3) cyc(idle_exp(1'b0, 1'b0));
        result_valid = 1'b0;

        // Randomized instructions.
        for (int i = 0; i < 40; i++) begin
            rsew = 2'($urandom_range(0, 3));
            rvl = 6'($urandom_range(0, 32));
            nb = (int'(rvl) + 3) / 4;
            fb = -1;
            if (nb > 0 && $urandom_range(0, 7) == 0) fb = int'($urandom_range(0, nb - 1));
            run_instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                      rsew, rvl, 1'($urandom_range(0, 1)), int'($urandom_range(40, 100)), fb,
                      int'($urandom_range(0, 2)));
        end

        repeat (2) cyc(idle_exp(1'b0, 1'b0));
        check("writes_drained", wr_q.size(), 32'd0);
        check("strobes_drained", st_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
